// File: rtl/register_file.sv
// Purpose : RV32I integer register file, 2**ADDR_WIDTH x DATA_WIDTH, x0 hardwired to zero.
// Latency : reads are combinational (0 cycles); writes land on the rising clk edge.
// Backpr. : none; every write with we=1 to a nonzero address is accepted.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset, clears every register, wins over a write
//   we           write enable for write port 2
//   addr_read0   read port 0 address (rs1)    -> data_read0
//   addr_read1   read port 1 address (rs2)    -> data_read1
//   addr_write2  write port 2 address (rd)
//   data_write2  write port 2 data
//
// Optional feature macro: REGFILE_WRITE_BYPASS_EN
//   When defined, a read whose address matches a live write (we=1, rst=0, rd!=0)
//   returns data_write2 in the same cycle. Stored state is identical either way.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_read0,
  input  logic [ADDR_WIDTH-1:0] addr_read1,
  input  logic [ADDR_WIDTH-1:0] addr_write2,
  input  logic [DATA_WIDTH-1:0] data_write2,
  output logic [DATA_WIDTH-1:0] data_read0,
  output logic [DATA_WIDTH-1:0] data_read1
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  wr_en;

  // A write only counts when not in reset and not aimed at x0; this same
  // qualifier gates forwarding so bypass and storage can never disagree.
  assign wr_en = we && !rst && (addr_write2 != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[addr_write2] = data_write2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    data_read0 = regs_q[addr_read0];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wr_en && (addr_read0 == addr_write2)) begin
      data_read0 = data_write2;
    end
`endif
    // x0 reads zero even if something ever lands in the storage slot.
    if (addr_read0 == '0) begin
      data_read0 = '0;
    end
  end

  always_comb begin
    data_read1 = regs_q[addr_read1];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wr_en && (addr_read1 == addr_write2)) begin
      data_read1 = data_write2;
    end
`endif
    if (addr_read1 == '0) begin
      data_read1 = '0;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Purpose : directed scoreboard bench for register_file.
// Latency : stimulus drives 1 time unit after posedge; monitor samples on negedge.
// Backpr. : n/a; the bench raises chk_vld for one half-cycle per expected read pair.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  addr_read0;
  logic [4:0]  addr_read1;
  logic [4:0]  addr_write2;
  logic [31:0] data_write2;
  logic [31:0] data_read0;
  logic [31:0] data_read1;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .addr_read0  (addr_read0),
    .addr_read1  (addr_read1),
    .addr_write2 (addr_write2),
    .data_write2 (data_write2),
    .data_read0  (data_read0),
    .data_read1  (data_read1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e0;
    logic [31:0] e1;
  } exp_t;

  exp_t exp_q[$];
  logic chk_vld;
  int   checks;
  int   errors;

  // Monitor: whenever a read is presented, pop the expected pair and compare.
  always @(negedge clk) begin
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: read presented with no expected entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (data_read0 !== e.e0) begin
          errors++;
          $display("FAIL read0[x%0d]: got 0x%08h expected 0x%08h", e.a0, data_read0, e.e0);
        end
        checks++;
        if (data_read1 !== e.e1) begin
          errors++;
          $display("FAIL read1[x%0d]: got 0x%08h expected 0x%08h", e.a1, data_read1, e.e1);
        end
      end
    end
  end

  task automatic push_and_present(input logic [4:0] a0, input logic [4:0] a1,
                                  input logic [31:0] e0, input logic [31:0] e1);
    exp_t e;
    addr_read0 = a0;
    addr_read1 = a1;
    e.a0 = a0; e.a1 = a1; e.e0 = e0; e.e1 = e1;
    exp_q.push_back(e);
    chk_vld = 1'b1;
    @(negedge clk);
    #1;
    chk_vld = 1'b0;
  endtask

  // Set up a write to be captured on the next rising edge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst = 1'b0;
    we = 1'b1;
    addr_write2 = a;
    data_write2 = d;
  endtask

  // After the pending edge, drop we and check a read pair.
  task automatic do_read(input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] e0, input logic [31:0] e1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    we = 1'b0;
    push_and_present(a0, a1, e0, e1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    chk_vld = 1'b0;
    rst = 1'b1;
    we = 1'b0;
    addr_read0 = '0;
    addr_read1 = '0;
    addr_write2 = '0;
    data_write2 = '0;

    // Reset: first edge clears everything.
    do_read(5'd0, 5'd0, 32'h0, 32'h0);
    do_read(5'd1, 5'd1, 32'h0, 32'h0);
    do_read(5'd31, 5'd31, 32'h0, 32'h0);

    // Basic write / read on both ports.
    do_write(5'd5, 32'hDEADBEEF);
    do_read(5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);

    // x0 ignores writes.
    do_write(5'd0, 32'hFFFFFFFF);
    do_read(5'd0, 5'd5, 32'h0, 32'hDEADBEEF);

    // we=0 must block a write even with address/data driven.
    do_write(5'd7, 32'h12345678);
    @(posedge clk);
    #1;
    we = 1'b0;
    addr_write2 = 5'd7;
    data_write2 = 32'hAAAAAAAA;
    do_read(5'd7, 5'd7, 32'h12345678, 32'h12345678);

    // Fill x1..x31 with 0x100+index, then read cross pairs.
    for (int i = 1; i < 32; i++) begin
      do_write(i[4:0], 32'h100 + i);
    end
    do_read(5'd1, 5'd31, 32'h101, 32'h11F);
    do_read(5'd31, 5'd1, 32'h11F, 32'h101);
    do_read(5'd16, 5'd16, 32'h110, 32'h110);
    do_read(5'd0, 5'd7, 32'h0, 32'h107);

    // Read during write to x9: before the edge the value depends on forwarding,
    // after the edge both configurations show the new data.
    @(posedge clk);
    #1;
    we = 1'b1;
    addr_write2 = 5'd9;
    data_write2 = 32'hCAFEF00D;
`ifdef REGFILE_WRITE_BYPASS_EN
    push_and_present(5'd9, 5'd9, 32'hCAFEF00D, 32'hCAFEF00D);
`else
    push_and_present(5'd9, 5'd9, 32'h109, 32'h109);
`endif
    do_read(5'd9, 5'd8, 32'hCAFEF00D, 32'h108);

    // Reset beats a simultaneous write.
    do_write(5'd3, 32'h55);
    do_read(5'd3, 5'd3, 32'h55, 32'h55);
    @(posedge clk);
    #1;
    rst = 1'b1;
    we = 1'b1;
    addr_write2 = 5'd3;
    data_write2 = 32'h77;
    do_read(5'd3, 5'd31, 32'h0, 32'h0);
    do_read(5'd9, 5'd1, 32'h0, 32'h0);

    // Drain: every expected entry must have been consumed.
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
